// File: rtl/reduce_pkg.sv
// Shared types and helpers for the sequential N-way reduction unit.
package reduce_pkg;

  typedef enum logic [1:0] {
    MODE_OR  = 2'b00,
    MODE_AND = 2'b01,
    MODE_XOR = 2'b10,
    MODE_NOR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Starting accumulator value: AND folds from 1, the others from 0.
  function automatic logic identity(input mode_e m);
    return (m == MODE_AND);
  endfunction

  // Result can no longer change once OR/NOR has seen a 1 or AND has seen a 0.
  function automatic logic decided(input mode_e m, input logic acc);
    logic d;
    case (m)
      MODE_OR, MODE_NOR: d = acc;
      MODE_AND:          d = ~acc;
      default:           d = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reduce_lane.sv
// Folds one LANES-bit slice into the running accumulator bit.
module reduce_lane
  import reduce_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  mode_e              mode,
  input  logic [LANES-1:0]   slice,
  input  logic               acc_in,
  output logic               acc_c
);

  // NOR accumulates as OR; the inversion happens when the result is stored.
  always_comb begin
    acc_c = acc_in;
    case (mode)
      MODE_AND: acc_c = acc_in & (&slice);
      MODE_XOR: acc_c = acc_in ^ (^slice);
      default:  acc_c = acc_in | (|slice);
    endcase
  end

endmodule

// File: rtl/reduce_nway_seq.sv
// Sequential WIDTH-bit OR/AND/XOR/NOR reduction, LANES bits per clock,
// with optional early termination once the result is decided.
module reduce_nway_seq
  import reduce_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned LANES      = 4,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             out
);

  localparam int unsigned STEPS = WIDTH / LANES;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  if ((WIDTH % LANES) != 0 || WIDTH < 2 || LANES < 1) begin : g_bad_params
    $error("reduce_nway_seq: WIDTH must be >= 2 and a multiple of LANES");
  end

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             acc_step;
  logic             accept;
  logic             last_step;

  reduce_lane #(.LANES(LANES)) u_lane (
    .mode   (mode_q),
    .slice  (sh_q[LANES-1:0]),
    .acc_in (acc_q),
    .acc_c  (acc_step)
  );

  assign accept    = start && (state_q != RUN);
  assign last_step = (cnt_q == CW'(1)) || (EARLY_EXIT && decided(mode_q, acc_step));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the operand/accumulator datapath.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      mode_d = mode_e'(mode);
      acc_d  = identity(mode_e'(mode));
      sh_d   = in;
      cnt_d  = CW'(STEPS);
    end else if (state_q == RUN) begin
      acc_d  = acc_step;
      sh_d   = sh_q >> LANES;
      cnt_d  = cnt_q - CW'(1);
    end
  end

  // Registered outputs decoded from the upcoming state.
  always_comb begin
    out_d   = out_q;
    done_d  = (state_d == DONE);
    busy_d  = (state_d == RUN);
    ready_d = (state_d != RUN);
    if (state_q == RUN && last_step) begin
      out_d = (mode_q == MODE_NOR) ? ~acc_step : acc_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_OR;
      acc_q   <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign out   = out_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign ready = ready_q;

endmodule
